// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache line transfer engine: line geometry,
// index widths, FSM state encoding and a RAM address helper.
package dcache_pkg;

  localparam int DCACHE_LINE_WORDS = 8;
  localparam int LINE_IDX_W        = 8;
  localparam int WORD_IDX_W        = 3;
  localparam int RAM_ADDR_W        = LINE_IDX_W + WORD_IDX_W;
  localparam int DATA_W            = 32;
  localparam int BE_W              = DATA_W / 8;

  typedef logic [LINE_IDX_W-1:0] line_idx_t;
  typedef logic [WORD_IDX_W-1:0] word_idx_t;
  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_EV_RD  = 3'd2,
    ST_EV_OUT = 3'd3,
    ST_DONE   = 3'd4
  } xfer_state_e;

  // RAM word address of a word inside a cache line
  function automatic ram_addr_t line_word_addr(input line_idx_t line, input word_idx_t word);
    return {line, word};
  endfunction

endpackage

// File: rtl/dcache_line_xfer.sv
// Data-cache line transfer engine: refills a line from the fill stream into
// the data RAM, or evicts a line from the RAM onto the write-back stream.
// Optional feature macro: DCACHE_XFER_CRIT_WORD_EN (critical-word-first
// refill starting at cmd_word_i; otherwise refill always starts at word 0).
module dcache_line_xfer
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  // command
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_evict_i,
  input  logic [LINE_IDX_W-1:0] cmd_line_i,
  input  logic [WORD_IDX_W-1:0] cmd_word_i,
  // refill stream in
  input  logic                  fill_valid_i,
  input  logic [DATA_W-1:0]     fill_data_i,
  output logic                  fill_ready_o,
  // write-back stream out
  output logic                  wb_valid_o,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic                  wb_last_o,
  input  logic                  wb_ready_i,
  // data RAM port
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0]     ram_data_o,
  output logic [BE_W-1:0]       ram_wr_o,
  input  logic [DATA_W-1:0]     ram_data_i,
  // status
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DCACHE_LINE_WORDS-1:0] word_valid_o
);

  xfer_state_e state_reg, state_next;

  logic                         ready_en_reg;   // holds cmd_ready_o low for the first cycle out of reset
  line_idx_t                    line_reg;
  word_idx_t                    start_reg;
  word_idx_t                    count_reg;
  logic [DCACHE_LINE_WORDS-1:0] word_valid_reg;
  ram_addr_t                    addr_hold_reg;
  logic [DATA_W-1:0]            wb_data_reg;
  logic                         wb_first_reg;   // first EV_OUT cycle: RAM read data arrives now

  logic      cmd_accept;
  logic      fill_beat;
  logic      wb_beat;
  word_idx_t fill_ofs;
  word_idx_t start_next;

  assign cmd_accept = cmd_valid_i && cmd_ready_o;
  assign fill_beat  = (state_reg == ST_FILL) && fill_valid_i;
  assign wb_beat    = (state_reg == ST_EV_OUT) && wb_ready_i;
  assign fill_ofs   = start_reg + count_reg;

`ifdef DCACHE_XFER_CRIT_WORD_EN
  assign start_next = cmd_word_i;
`else
  logic unused_cmd_word;
  assign unused_cmd_word = ^cmd_word_i;
  assign start_next      = '0;
`endif

  // State register; reset returns to IDLE at once, which also kills ram_wr_o
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_accept) state_next = cmd_evict_i ? ST_EV_RD : ST_FILL;
      end
      ST_FILL: begin
        if (fill_beat && (count_reg == word_idx_t'(DCACHE_LINE_WORDS - 1))) state_next = ST_DONE;
      end
      ST_EV_RD: begin
        state_next = ST_EV_OUT;
      end
      ST_EV_OUT: begin
        if (wb_beat) begin
          state_next = (count_reg == word_idx_t'(DCACHE_LINE_WORDS - 1)) ? ST_DONE : ST_EV_RD;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode; RAM address holds its previous value whenever the port is idle
  always_comb begin
    cmd_ready_o  = (state_reg == ST_IDLE) && ready_en_reg;
    fill_ready_o = (state_reg == ST_FILL);
    busy_o       = (state_reg != ST_IDLE);
    done_o       = (state_reg == ST_DONE);
    wb_valid_o   = (state_reg == ST_EV_OUT);
    wb_last_o    = (state_reg == ST_EV_OUT) && (count_reg == word_idx_t'(DCACHE_LINE_WORDS - 1));
    wb_data_o    = wb_first_reg ? ram_data_i : wb_data_reg;
    ram_addr_o   = addr_hold_reg;
    ram_data_o   = '0;
    ram_wr_o     = '0;
    word_valid_o = word_valid_reg;
    if (fill_beat) begin
      ram_addr_o = line_word_addr(line_reg, fill_ofs);
      ram_data_o = fill_data_i;
      ram_wr_o   = '1;
    end else if (state_reg == ST_EV_RD) begin
      ram_addr_o = line_word_addr(line_reg, count_reg);
    end
  end

  // Command latch, beat counter, held RAM address and write-back data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg  <= 1'b0;
      line_reg      <= '0;
      start_reg     <= '0;
      count_reg     <= '0;
      addr_hold_reg <= '0;
      wb_data_reg   <= '0;
      wb_first_reg  <= 1'b0;
    end else begin
      ready_en_reg  <= 1'b1;
      addr_hold_reg <= ram_addr_o;
      wb_first_reg  <= (state_reg == ST_EV_RD);
      if (state_reg == ST_EV_OUT) wb_data_reg <= wb_data_o;
      if (cmd_accept) begin
        line_reg  <= cmd_line_i;
        start_reg <= cmd_evict_i ? word_idx_t'(0) : start_next;
        count_reg <= '0;
      end else if (fill_beat || wb_beat) begin
        count_reg <= count_reg + word_idx_t'(1);
      end
    end
  end

  // Per-word valid flags: cleared by a new refill, set as each word lands
  for (genvar gi = 0; gi < DCACHE_LINE_WORDS; gi++) begin : g_word_valid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                          word_valid_reg[gi] <= 1'b0;
      else if (cmd_accept && !cmd_evict_i)                 word_valid_reg[gi] <= 1'b0;
      else if (fill_beat && (fill_ofs == word_idx_t'(gi))) word_valid_reg[gi] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_line_xfer.sv
// Directed testbench for dcache_line_xfer with a behavioural single-port
// registered-read RAM. Expectations follow the build's critical-word option.
module tb_dcache_line_xfer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_evict_i;
  logic [7:0]  cmd_line_i;
  logic [2:0]  cmd_word_i;
  logic        fill_valid_i, fill_ready_o;
  logic [31:0] fill_data_i;
  logic        wb_valid_o, wb_last_o, wb_ready_i;
  logic [31:0] wb_data_o;
  logic [10:0] ram_addr_o;
  logic [31:0] ram_data_o, ram_data_i;
  logic [3:0]  ram_wr_o;
  logic        busy_o, done_o;
  logic [7:0]  word_valid_o;

  int checks   = 0;
  int failures = 0;

`ifdef DCACHE_XFER_CRIT_WORD_EN
  localparam logic [2:0] CW_START = 3'd5;
`else
  localparam logic [2:0] CW_START = 3'd0;
`endif

  dcache_line_xfer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_evict_i  (cmd_evict_i),
    .cmd_line_i   (cmd_line_i),
    .cmd_word_i   (cmd_word_i),
    .fill_valid_i (fill_valid_i),
    .fill_data_i  (fill_data_i),
    .fill_ready_o (fill_ready_o),
    .wb_valid_o   (wb_valid_o),
    .wb_data_o    (wb_data_o),
    .wb_last_o    (wb_last_o),
    .wb_ready_i   (wb_ready_i),
    .ram_addr_o   (ram_addr_o),
    .ram_data_o   (ram_data_o),
    .ram_wr_o     (ram_wr_o),
    .ram_data_i   (ram_data_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .word_valid_o (word_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data RAM: read-first, one-cycle registered read, plus a bench preload port
  logic [31:0] mem [0:2047];
  logic        tb_wr_en;
  logic [10:0] tb_wr_addr;
  logic [31:0] tb_wr_data;
  always @(posedge clk) begin
    ram_data_i <= mem[ram_addr_o];
    if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
    for (int b = 0; b < 4; b++) begin
      if (ram_wr_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // move to the middle of the cycle where combinational outputs are settled
  task automatic mid();
    #4;
  endtask

  task automatic issue_cmd(input logic evict, input logic [7:0] line, input logic [2:0] word);
    cmd_valid_i = 1'b1;
    cmd_evict_i = evict;
    cmd_line_i  = line;
    cmd_word_i  = word;
    mid();
    chk("cmd_ready_idle", {31'b0, cmd_ready_o}, 32'd1);
    step();
    cmd_valid_i = 1'b0;
    $display("cmd evict=%0d line=0x%02h word=%0d accepted", evict, line, word);
  endtask

  initial begin
    rst_n        = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_evict_i  = 1'b0;
    cmd_line_i   = '0;
    cmd_word_i   = '0;
    fill_valid_i = 1'b0;
    fill_data_i  = '0;
    wb_ready_i   = 1'b0;
    tb_wr_en     = 1'b0;
    tb_wr_addr   = '0;
    tb_wr_data   = '0;

    // preload line 0xFF with 0xB0..0xB7 while in reset
    for (int i = 0; i < 8; i++) begin
      tb_wr_en   = 1'b1;
      tb_wr_addr = 11'h7F8 + 11'(i);
      tb_wr_data = 32'hB0 + 32'(i);
      step();
    end
    tb_wr_en = 1'b0;

    // reset values
    mid();
    chk("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_ram_wr", {28'b0, ram_wr_o}, 32'd0);
    chk("rst_ram_addr", {21'b0, ram_addr_o}, 32'd0);
    chk("rst_word_valid", {24'b0, word_valid_o}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid_o}, 32'd0);
    step();
    rst_n = 1'b1;
    mid();
    chk("rel_cmd_ready_low", {31'b0, cmd_ready_o}, 32'd0);
    step();

    // refill line 0x12 from word 0 with one stall cycle
    issue_cmd(1'b0, 8'h12, 3'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        fill_valid_i = 1'b0;
        mid();
        chk("fill_gap_wr", {28'b0, ram_wr_o}, 32'd0);
        chk("fill_gap_busy", {31'b0, busy_o}, 32'd1);
        step();
      end
      fill_valid_i = 1'b1;
      fill_data_i  = 32'hA0 + 32'(i);
      mid();
      chk("fill_ready", {31'b0, fill_ready_o}, 32'd1);
      chk("fill_wr", {28'b0, ram_wr_o}, 32'hF);
      chk("fill_addr", {21'b0, ram_addr_o}, 32'h090 + 32'(i));
      chk("fill_data", ram_data_o, 32'hA0 + 32'(i));
      if (i == 1) chk("fill_wv_first", {24'b0, word_valid_o}, 32'h01);
      $display("fill beat %0d addr=0x%03h data=0x%08h wr=0x%0h", i, ram_addr_o, ram_data_o, ram_wr_o);
      step();
    end
    fill_valid_i = 1'b0;
    mid();
    chk("fill_done", {31'b0, done_o}, 32'd1);
    chk("fill_wv_all", {24'b0, word_valid_o}, 32'hFF);
    chk("fill_done_wr", {28'b0, ram_wr_o}, 32'd0);
    step();
    mid();
    chk("fill_done_pulse", {31'b0, done_o}, 32'd0);
    chk("fill_idle_busy", {31'b0, busy_o}, 32'd0);
    for (int i = 0; i < 8; i++) chk("fill_mem", mem[11'h090 + 11'(i)], 32'hA0 + 32'(i));
    step();

    // evict line 0xFF, beat 3 back-pressured for 5 cycles
    issue_cmd(1'b1, 8'hFF, 3'd6);
    for (int i = 0; i < 8; i++) begin
      wb_ready_i = 1'b0;
      mid();
      chk("ev_rd_valid", {31'b0, wb_valid_o}, 32'd0);
      chk("ev_rd_addr", {21'b0, ram_addr_o}, 32'h7F8 + 32'(i));
      chk("ev_rd_wr", {28'b0, ram_wr_o}, 32'd0);
      step();
      if (i == 3) begin
        for (int s = 0; s < 5; s++) begin
          mid();
          chk("ev_hold_valid", {31'b0, wb_valid_o}, 32'd1);
          chk("ev_hold_data", wb_data_o, 32'hB3);
          chk("ev_hold_last", {31'b0, wb_last_o}, 32'd0);
          step();
        end
      end
      wb_ready_i = 1'b1;
      mid();
      chk("ev_out_valid", {31'b0, wb_valid_o}, 32'd1);
      chk("ev_out_data", wb_data_o, 32'hB0 + 32'(i));
      chk("ev_out_last", {31'b0, wb_last_o}, (i == 7) ? 32'd1 : 32'd0);
      chk("ev_out_wr", {28'b0, ram_wr_o}, 32'd0);
      $display("evict beat %0d data=0x%08h last=%0d", i, wb_data_o, wb_last_o);
      step();
    end
    wb_ready_i = 1'b0;
    mid();
    chk("ev_done", {31'b0, done_o}, 32'd1);
    chk("ev_done_valid", {31'b0, wb_valid_o}, 32'd0);
    step();
    mid();
    chk("ev_idle_ready", {31'b0, cmd_ready_o}, 32'd1);
    step();

    // reset during refill beat 4
    issue_cmd(1'b0, 8'h30, 3'd0);
    for (int i = 0; i < 4; i++) begin
      fill_valid_i = 1'b1;
      fill_data_i  = 32'hC0 + 32'(i);
      step();
    end
    fill_data_i = 32'hC4;
    #2;
    chk("rstmid_wr_before", {28'b0, ram_wr_o}, 32'hF);
    rst_n = 1'b0;
    #1;
    chk("rstmid_wr", {28'b0, ram_wr_o}, 32'd0);
    chk("rstmid_busy", {31'b0, busy_o}, 32'd0);
    chk("rstmid_fill_ready", {31'b0, fill_ready_o}, 32'd0);
    chk("rstmid_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
    chk("rstmid_wv", {24'b0, word_valid_o}, 32'd0);
    chk("rstmid_addr", {21'b0, ram_addr_o}, 32'd0);
    chk("rstmid_done", {31'b0, done_o}, 32'd0);
    $display("reset asserted during refill beat 4");
    fill_valid_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // refill line 0x01 requesting word 5 (start depends on critical-word option)
    issue_cmd(1'b0, 8'h01, 3'd5);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ofs;
      ofs          = CW_START + 3'(i);
      fill_valid_i = 1'b1;
      fill_data_i  = 32'hD0 + 32'(i);
      mid();
      chk("cw_addr", {21'b0, ram_addr_o}, 32'h008 + 32'(ofs));
      chk("cw_wr", {28'b0, ram_wr_o}, 32'hF);
      if (i == 1) chk("cw_wv_first", {24'b0, word_valid_o}, 32'd1 << CW_START);
      $display("cw fill beat %0d addr=0x%03h data=0x%08h", i, ram_addr_o, ram_data_o);
      step();
    end
    fill_valid_i = 1'b0;
    mid();
    chk("cw_done", {31'b0, done_o}, 32'd1);
    chk("cw_wv_all", {24'b0, word_valid_o}, 32'hFF);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
